pulse_tx_stretcher: RTL
=======================

PULSE_TX_STRETCHER -- requirements
Module: pulse_tx_stretcher

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, giving the minimum cycles `signal` stays high per transfer (legal range 1 to 255).
REQ-002 SHALL have parameter GAP_CYCLES, default 4, giving the minimum cycles `signal` stays low between transfers (legal range 1 to 255).
REQ-003 SHALL have parameter CNT_W, default 4, giving the width of the pending-pulse counter.
REQ-004 SHALL have parameter USE_ACK, default 1; when 1, each transfer waits for the remote acknowledge level.
REQ-005 SHALL have port clk, input, 1 bit: the single source-domain clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port pulse_in, input, 1 bit: single-cycle event request, sampled every clk.
REQ-008 SHALL have port ack_in, input, 1 bit: asynchronous acknowledge level returned from the slower domain.
REQ-009 SHALL have port clear_ovf, input, 1 bit: synchronous clear of the overflow flag.
REQ-010 SHALL have port signal, output, 1 bit: registered, stretched level sent to the slower domain's edge detector.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-012 SHALL have port pending, output, CNT_W bits: the count of accepted events not yet launched.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag indicating an event was dropped.

Function
REQ-014 SHALL synchronize ack_in through two flops, ack_s1 then ack_s2; all FSM decisions SHALL use ack_s2 only.
REQ-015 SHALL implement the states IDLE, HIGH, WAIT_ACK, LOW, WAIT_REL and no others.
REQ-016 SHALL leave IDLE for HIGH in the same cycle that (pending != 0 or pulse_in = 1), setting signal = 1 at the next edge.
REQ-017 SHALL therefore show 1-cycle latency: pulse_in at edge n with FSM in IDLE and pending = 0 gives signal = 1 after edge n+1.
REQ-018 SHALL hold HIGH for exactly HOLD_CYCLES cycles, then go to WAIT_ACK if USE_ACK = 1, else to LOW.
REQ-019 SHALL stay in WAIT_ACK with signal = 1 until ack_s2 = 1, then go to LOW.
REQ-020 SHALL drive signal = 0 in LOW and hold LOW for exactly GAP_CYCLES cycles, then go to WAIT_REL if USE_ACK = 1, else to IDLE.
REQ-021 SHALL stay in WAIT_REL until ack_s2 = 0, then go to IDLE.
REQ-022 SHALL make signal a direct flop output, high only in HIGH and WAIT_ACK.
REQ-023 SHALL accept pulse_in in any state: it increments pending, except that a pulse_in consumed directly by the IDLE-to-HIGH launch leaves pending unchanged.
REQ-024 SHALL decrement pending on every IDLE-to-HIGH launch that is not served by a simultaneous pulse_in.
REQ-025 SHALL leave pending unchanged when increment and decrement coincide.
REQ-026 SHALL, when pending = 2^CNT_W - 1 and an increment is required, drop the event, keep pending at its maximum, and set overflow = 1; pending SHALL never wrap.
REQ-027 SHALL keep overflow set until clear_ovf = 1; when a clear coincides with a new drop, the set wins.
REQ-028 SHALL launch back-to-back queued events with no extra IDLE dwell beyond one cycle.
REQ-029 SHALL generate no transfer for any ack_s2 transition outside WAIT_ACK or WAIT_REL.

Reset
REQ-030 SHALL, on rst = 1, asynchronously force state = IDLE, signal = 0, busy = 0, pending = 0, overflow = 0, both hold/gap counters = 0, and ack_s1 = ack_s2 = 0.
REQ-031 SHALL discard any in-flight transfer and all queued events when rst is asserted mid-operation, with signal falling immediately and asynchronously.
REQ-032 SHALL resume normal operation on the first clk edge after rst deasserts, with no spurious signal pulse.

Verification
REQ-033 SHALL be covered by this scenario: USE_ACK = 0, HOLD = 4, GAP = 4, single pulse_in at cycle 10 -> signal high cycles 11-14, low from 15, busy low from cycle 19, pending stays 0.
REQ-034 SHALL be covered by this scenario: USE_ACK = 0, three pulse_in on consecutive cycles -> pending reads 1 then 2, exactly three signal high windows of 4 cycles each separated by at least 4 low cycles, pending ends at 0.
REQ-035 SHALL be covered by this scenario: USE_ACK = 1, with ack_in raised 7 cycles after signal rises and dropped 3 cycles after signal falls -> signal stays high until 2 cycles after ack_in rises, and busy clears 2 cycles after ack_in falls (provided GAP has elapsed).
REQ-036 SHALL be covered by this scenario: CNT_W = 2, USE_ACK = 1 with ack_in held at 0, five pulses -> first pulse launches, pending saturates at 3, one event dropped, overflow = 1 until clear_ovf.
REQ-037 SHALL be covered by this scenario: rst asserted during WAIT_ACK with pending = 2 -> signal = 0, pending = 0, overflow = 0 with no clk edge needed, and no transfer occurs after release.
REQ-038 SHALL be covered by this scenario: pulse_in coincident with the IDLE-to-HIGH launch while pending = 1 -> pending remains 1, and a second transfer follows the first.

Source files
------------

// File: rtl/pulse_tx_stretcher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pulse_tx_stretcher                                          |
// | Brief    : Queues single-cycle events and replays each as a stretched  |
// |            level pulse, with optional ack handshake, for a slow domain.|
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module pulse_tx_stretcher #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 4,
    parameter bit USE_ACK     = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             ack_in,
    input  logic             clear_ovf,
    output logic             signal,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_high     = 3'd1;
    localparam logic [2:0] c_st_wait_ack = 3'd2;
    localparam logic [2:0] c_st_low      = 3'd3;
    localparam logic [2:0] c_st_wait_rel = 3'd4;

    localparam logic [7:0]       c_hold_last = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]       c_gap_last  = 8'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pend_max  = '1;
    localparam logic [CNT_W-1:0] c_pend_one  = CNT_W'(1);

    logic [2:0]       r_state;
    logic             r_signal;
    logic             r_busy;
    logic [CNT_W-1:0] r_pending;
    logic             r_overflow;
    logic [7:0]       r_hold_cnt;
    logic [7:0]       r_gap_cnt;
    logic             r_ack_s1;
    logic             r_ack_s2;

    logic w_launch;
    logic w_inc;
    logic w_dec;
    logic w_full;
    logic w_drop;

    // A pulse arriving on the launch cycle is served directly and never queued.
    assign w_launch = (r_state == c_st_idle) && ((r_pending != '0) || pulse_in);
    assign w_inc    = pulse_in && !w_launch;
    assign w_dec    = w_launch && !pulse_in;
    assign w_full   = (r_pending == c_pend_max);
    assign w_drop   = w_inc && w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
        end else begin
            r_ack_s1 <= ack_in;
            r_ack_s2 <= r_ack_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_dec) begin
                r_pending <= r_pending - c_pend_one;
            end else if (w_inc && !w_full) begin
                r_pending <= r_pending + c_pend_one;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_signal   <= 1'b0;
            r_busy     <= 1'b0;
            r_hold_cnt <= 8'd0;
            r_gap_cnt  <= 8'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_launch) begin
                        r_state    <= c_st_high;
                        r_signal   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= 8'd0;
                    end
                end
                c_st_high: begin
                    if (r_hold_cnt == c_hold_last) begin
                        r_hold_cnt <= 8'd0;
                        if (USE_ACK) begin
                            r_state <= c_st_wait_ack;
                        end else begin
                            r_state   <= c_st_low;
                            r_signal  <= 1'b0;
                            r_gap_cnt <= 8'd0;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                c_st_wait_ack: begin
                    if (r_ack_s2) begin
                        r_state   <= c_st_low;
                        r_signal  <= 1'b0;
                        r_gap_cnt <= 8'd0;
                    end
                end
                c_st_low: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_gap_cnt <= 8'd0;
                        if (USE_ACK) begin
                            r_state <= c_st_wait_rel;
                        end else begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                c_st_wait_rel: begin
                    if (!r_ack_s2) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= c_st_idle;
                    r_signal <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign signal   = r_signal;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
